// File: rtl/ws2812b_meter_sched.sv
// Frame scheduler and level-to-bar-graph controller feeding a WS2812B meter driver.
// Latency: tick (or queued tick) to frame_start is 2 cycles; bar outputs change on the UPDATE->START edge.
// Backpressure: driver stalls via frame_done; one tick seen while busy is queued, the rest only set overrun.
module ws2812b_meter_sched #(
   parameter int CLK_PERIOD_NS    = 10,
   parameter int FRAME_PERIOD_US  = 16667,
   parameter int LED_N            = 60,
   parameter int LEVEL_W          = 16,
   parameter int DECAY_STEP       = 1,
   parameter int PEAK_HOLD_FRAMES = 30
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   input  logic               level_valid,
   input  logic [LEVEL_W-1:0] level,
   input  logic               frame_done,
   output logic               drv_enable,
   output logic               frame_start,
   output logic [15:0]        on_count,
   output logic [15:0]        peak_count,
   output logic [15:0]        max_count,
   output logic               overrun
);

   localparam int FRAME_CYCLES = (FRAME_PERIOD_US * 1000) / CLK_PERIOD_NS;
   localparam int TICK_W       = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
   localparam int PROD_W       = LEVEL_W + 17;

   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(FRAME_CYCLES - 1);
   localparam logic [15:0]       LED_MAX   = 16'(LED_N);
   localparam logic [15:0]       DECAY     = 16'(DECAY_STEP);
   localparam logic [15:0]       HOLD_INIT = 16'(PEAK_HOLD_FRAMES);

   typedef enum logic [2:0] {
      IDLE,
      ARMED,
      UPDATE,
      START,
      BUSY
   } state_t;

   state_t              state;
   state_t              stateNext;
   logic [TICK_W-1:0]   tickCnt;
   logic                tick;
   logic                pending;
   logic [15:0]         frameMax;
   logic [15:0]         holdCnt;

   logic [PROD_W-1:0]   product;
   logic [PROD_W-1:0]   scaledFull;
   logic [15:0]         target;
   logic [15:0]         decayedOn;
   logic [15:0]         decayedPeak;
   logic [15:0]         nextOn;
   logic [15:0]         nextPeak;
   logic [15:0]         nextHold;

   assign max_count = LED_MAX;
   assign tick      = (state != IDLE) && (tickCnt == TICK_LAST);

   // Level to LED count: full-width product so nothing is lost before the shift.
   assign product    = PROD_W'(level) * PROD_W'(LED_N + 1);
   assign scaledFull = product >> LEVEL_W;
   assign target     = (scaledFull > PROD_W'(LED_N)) ? LED_MAX : scaledFull[15:0];

   // New bar length and peak marker for the frame being closed.
   always_comb begin
      decayedOn   = (on_count > DECAY) ? (on_count - DECAY) : 16'd0;
      decayedPeak = (peak_count > DECAY) ? (peak_count - DECAY) : 16'd0;
      nextOn      = on_count;
      nextPeak    = peak_count;
      nextHold    = holdCnt;
      if (frameMax >= on_count) begin
         nextOn = frameMax;
      end else begin
         nextOn = (frameMax > decayedOn) ? frameMax : decayedOn;
      end
      if (nextOn >= peak_count) begin
         nextPeak = nextOn;
         nextHold = HOLD_INIT;
      end else if (holdCnt != 16'd0) begin
         nextHold = holdCnt - 16'd1;
      end else begin
         nextPeak = (nextOn > decayedPeak) ? nextOn : decayedPeak;
      end
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // Next-state decode and Moore outputs to the driver.
   always_comb begin
      stateNext   = state;
      drv_enable  = (state != IDLE);
      frame_start = 1'b0;
      case (state)
         IDLE: begin
            if (enable) stateNext = ARMED;
         end
         ARMED: begin
            if (!enable) begin
               stateNext = IDLE;
            end else if (tick || pending) begin
               stateNext = UPDATE;
            end
         end
         UPDATE: begin
            stateNext = START;
         end
         START: begin
            frame_start = 1'b1;
            stateNext   = BUSY;
         end
         BUSY: begin
            if (frame_done) stateNext = enable ? ARMED : IDLE;
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   // Frame tick counter: free-runs while active, parked at zero in IDLE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tickCnt <= '0;
      end else if (state == IDLE || tickCnt == TICK_LAST) begin
         tickCnt <= '0;
      end else begin
         tickCnt <= tickCnt + TICK_W'(1);
      end
   end

   // Single-entry tick queue plus sticky overrun for ticks that land while the driver is busy.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending <= 1'b0;
         overrun <= 1'b0;
      end else begin
         if (state == IDLE) begin
            pending <= 1'b0;
         end else if (state == UPDATE) begin
            pending <= tick;
         end else if (tick && state != ARMED) begin
            pending <= 1'b1;
         end
         if (state == IDLE && enable) begin
            overrun <= 1'b0;
         end else if (state == BUSY && tick) begin
            overrun <= 1'b1;
         end
      end
   end

   // Frame maximum; a sample in the UPDATE cycle opens the next window.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         frameMax <= 16'd0;
      end else if (state == UPDATE) begin
         frameMax <= level_valid ? target : 16'd0;
      end else if (state != IDLE && level_valid && target > frameMax) begin
         frameMax <= target;
      end
   end

   // Bar registers only move in UPDATE so the driver never sees a partial change.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         on_count   <= 16'd0;
         peak_count <= 16'd0;
         holdCnt    <= 16'd0;
      end else if (state == UPDATE) begin
         on_count   <= nextOn;
         peak_count <= nextPeak;
         holdCnt    <= nextHold;
      end
   end

endmodule

// File: tb/tb_ws2812b_meter_sched.sv
// Scenario bench for ws2812b_meter_sched: 100-cycle frames, 60 LEDs, peak hold of 3 frames.
// Expected bar values come from a small behavioural model pushed into a scoreboard.
// Every wait on the DUT is bounded; timeouts count as miscompares.
module tb_ws2812b_meter_sched;

   localparam int LED_N = 60;
   localparam int HOLD  = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic        level_valid;
   logic [15:0] level;
   logic        frame_done;
   logic        drv_enable;
   logic        frame_start;
   logic [15:0] on_count;
   logic [15:0] peak_count;
   logic [15:0] max_count;
   logic        overrun;

   ws2812b_meter_sched #(
      .CLK_PERIOD_NS(10),
      .FRAME_PERIOD_US(1),
      .LED_N(LED_N),
      .LEVEL_W(16),
      .DECAY_STEP(1),
      .PEAK_HOLD_FRAMES(HOLD)
   ) dut (
      .clk(clk),
      .reset(reset),
      .enable(enable),
      .level_valid(level_valid),
      .level(level),
      .frame_done(frame_done),
      .drv_enable(drv_enable),
      .frame_start(frame_start),
      .on_count(on_count),
      .peak_count(peak_count),
      .max_count(max_count),
      .overrun(overrun)
   );

   always #5 clk = ~clk;

   typedef struct {
      int on;
      int peak;
   } exp_t;

   exp_t sb[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   mOn, mPeak, mHold, mMax;

   // ---------------- reference model ----------------
   function automatic int mapLevel(input int lvl);
      longint p;
      int     t;
      p = longint'(lvl) * longint'(LED_N + 1);
      t = int'(p >>> 16);
      return (t > LED_N) ? LED_N : t;
   endfunction

   task automatic modelClear();
      mOn = 0; mPeak = 0; mHold = 0; mMax = 0;
      sb.delete();
   endtask

   task automatic modelSample(input int lvl);
      int t;
      t = mapLevel(lvl);
      if (t > mMax) mMax = t;
   endtask

   task automatic modelFrame();
      int   n, dOn, dPk;
      exp_t e;
      dOn = (mOn > 1) ? mOn - 1 : 0;
      if (mMax >= mOn) n = mMax;
      else n = (mMax > dOn) ? mMax : dOn;
      if (n >= mPeak) begin
         mPeak = n;
         mHold = HOLD;
      end else if (mHold > 0) begin
         mHold = mHold - 1;
      end else begin
         dPk   = (mPeak > 1) ? mPeak - 1 : 0;
         mPeak = (n > dPk) ? n : dPk;
      end
      mOn  = n;
      mMax = 0;
      e.on = mOn;
      e.peak = mPeak;
      sb.push_back(e);
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic doReset();
      reset = 1'b1; enable = 1'b0; level_valid = 1'b0; frame_done = 1'b0; level = 16'd0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      modelClear();
   endtask

   task automatic sendLevel(input int lvl);
      level = 16'(lvl);
      level_valid = 1'b1;
      @(negedge clk);
      level_valid = 1'b0;
   endtask

   task automatic waitStart(input int budget, output logic ok, output int cyc);
      ok = 1'b0;
      cyc = 0;
      while (cyc < budget && !ok) begin
         @(negedge clk);
         cyc++;
         if (frame_start) ok = 1'b1;
      end
   endtask

   task automatic pulseDone(input int delay);
      repeat (delay) @(negedge clk);
      frame_done = 1'b1;
      @(negedge clk);
      frame_done = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset = 1'b1; enable = 1'b0; level_valid = 1'b0; frame_done = 1'b0; level = 16'd0;
      #7;
      vectors++;
      if (drv_enable !== 1'b0 || frame_start !== 1'b0 || on_count !== 16'd0 || peak_count !== 16'd0 ||
          max_count !== 16'd60 || overrun !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_outputs drv=%b start=%b on=%0d peak=%0d max=%0d ovr=%b required 0 0 0 0 60 0",
                  drv_enable, frame_start, on_count, peak_count, max_count, overrun);
      end
      enable = 1'b1;
      repeat (3) @(negedge clk);
      vectors++;
      if (drv_enable !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_holds_idle drv=%b required 0", drv_enable);
      end
      enable = 1'b0;
   endtask

   task automatic test_attack();
      logic ok; int cyc; exp_t e;
      doReset();
      enable = 1'b1;
      @(negedge clk);
      sendLevel(16'h8000);
      modelSample(16'h8000);
      modelFrame();
      waitStart(200, ok, cyc);
      vectors++;
      if (!ok || cyc != 100) begin
         miscompares++;
         $display("FAIL attack_first_start ok=%b cycles=%0d required 100", ok, cyc);
      end
      vectors++;
      if (sb.size() == 0) begin
         miscompares++;
         $display("FAIL attack_half scoreboard empty");
      end else begin
         e = sb.pop_front();
         if (on_count !== 16'(e.on) || peak_count !== 16'(e.peak) || on_count !== 16'd30) begin
            miscompares++;
            $display("FAIL attack_half on=%0d peak=%0d required %0d/%0d", on_count, peak_count, e.on, e.peak);
         end
      end
      pulseDone(10);
      sendLevel(16'hFFFF);
      modelSample(16'hFFFF);
      modelFrame();
      waitStart(200, ok, cyc);
      vectors++;
      if (!ok || sb.size() == 0) begin
         miscompares++;
         $display("FAIL attack_full_timeout ok=%b queued=%0d", ok, sb.size());
      end else begin
         e = sb.pop_front();
         if (on_count !== 16'(e.on) || peak_count !== 16'(e.peak) || on_count !== 16'd60) begin
            miscompares++;
            $display("FAIL attack_full on=%0d peak=%0d required %0d/%0d", on_count, peak_count, e.on, e.peak);
         end
      end
      pulseDone(10);
   endtask

   task automatic test_decay();
      logic ok; int cyc; exp_t e;
      doReset();
      enable = 1'b1;
      @(negedge clk);
      sendLevel(42975);
      modelSample(42975);
      modelFrame();
      for (int f = 0; f < 48; f++) begin
         waitStart(200, ok, cyc);
         vectors++;
         if (!ok || sb.size() == 0) begin
            miscompares++;
            $display("FAIL decay_timeout frame=%0d ok=%b", f, ok);
         end else begin
            e = sb.pop_front();
            if (on_count !== 16'(e.on) || peak_count !== 16'(e.peak)) begin
               miscompares++;
               $display("FAIL decay_frame f=%0d on=%0d peak=%0d required %0d/%0d",
                        f, on_count, peak_count, e.on, e.peak);
            end
         end
         vectors++;
         if (peak_count < on_count) begin
            miscompares++;
            $display("FAIL decay_peak_below_on f=%0d on=%0d peak=%0d", f, on_count, peak_count);
         end
         if (f >= 1 && f <= 3) begin
            vectors++;
            if (peak_count !== 16'd40 || on_count !== 16'(40 - f)) begin
               miscompares++;
               $display("FAIL decay_hold f=%0d on=%0d peak=%0d required %0d/40", f, on_count, peak_count, 40 - f);
            end
         end
         pulseDone(10);
         modelFrame();
      end
      vectors++;
      if (on_count !== 16'd0 || peak_count !== 16'd0) begin
         miscompares++;
         $display("FAIL decay_floor on=%0d peak=%0d required 0/0", on_count, peak_count);
      end
   endtask

   task automatic test_overrun();
      logic ok; int cyc; int starts; exp_t e;
      doReset();
      enable = 1'b1;
      modelFrame();
      waitStart(200, ok, cyc);
      vectors++;
      if (!ok || cyc != 102 || sb.size() == 0) begin
         miscompares++;
         $display("FAIL ovr_first_start ok=%b cycles=%0d required 102", ok, cyc);
      end else begin
         e = sb.pop_front();
      end
      modelFrame();
      starts = 0;
      repeat (250) begin
         @(negedge clk);
         if (frame_start) starts++;
      end
      vectors++;
      if (starts != 0 || overrun !== 1'b1 || drv_enable !== 1'b1) begin
         miscompares++;
         $display("FAIL ovr_withheld starts=%0d ovr=%b drv=%b required 0 1 1", starts, overrun, drv_enable);
      end
      frame_done = 1'b1;
      @(negedge clk);
      frame_done = 1'b0;
      waitStart(20, ok, cyc);
      vectors++;
      if (!ok || cyc != 2 || sb.size() == 0) begin
         miscompares++;
         $display("FAIL ovr_pending_start ok=%b cycles=%0d required 2", ok, cyc);
      end else begin
         e = sb.pop_front();
         if (on_count !== 16'(e.on) || peak_count !== 16'(e.peak)) begin
            miscompares++;
            $display("FAIL ovr_pending_vals on=%0d peak=%0d required %0d/%0d", on_count, peak_count, e.on, e.peak);
         end
      end
      pulseDone(10);
      modelFrame();
      waitStart(100, ok, cyc);
      vectors++;
      if (!ok || cyc != 36 || sb.size() == 0) begin
         miscompares++;
         $display("FAIL ovr_next_regular ok=%b cycles=%0d required 36", ok, cyc);
      end else begin
         e = sb.pop_front();
      end
      vectors++;
      if (overrun !== 1'b1) begin
         miscompares++;
         $display("FAIL ovr_sticky ovr=%b required 1", overrun);
      end
   endtask

   // Runs straight after test_overrun, sitting on the START cycle of a frame.
   task automatic test_disable();
      logic ok; int cyc; int starts; exp_t e;
      repeat (3) @(negedge clk);
      enable = 1'b0;
      repeat (3) @(negedge clk);
      vectors++;
      if (drv_enable !== 1'b1) begin
         miscompares++;
         $display("FAIL dis_hold_drv drv=%b required 1", drv_enable);
      end
      pulseDone(2);
      vectors++;
      if (drv_enable !== 1'b0 || overrun !== 1'b1) begin
         miscompares++;
         $display("FAIL dis_after_done drv=%b ovr=%b required 0 1", drv_enable, overrun);
      end
      starts = 0;
      repeat (200) begin
         @(negedge clk);
         if (frame_start || drv_enable) starts++;
      end
      vectors++;
      if (starts != 0) begin
         miscompares++;
         $display("FAIL dis_idle_quiet active_cycles=%0d required 0", starts);
      end
      enable = 1'b1;
      @(negedge clk);
      vectors++;
      if (drv_enable !== 1'b1 || overrun !== 1'b0) begin
         miscompares++;
         $display("FAIL dis_reenable drv=%b ovr=%b required 1 0", drv_enable, overrun);
      end
      modelFrame();
      waitStart(200, ok, cyc);
      vectors++;
      if (!ok || cyc != 101 || sb.size() == 0) begin
         miscompares++;
         $display("FAIL dis_restart ok=%b cycles=%0d required 101", ok, cyc);
      end else begin
         e = sb.pop_front();
      end
      pulseDone(10);
   endtask

   task automatic test_boundary();
      logic ok; int cyc; exp_t e;
      doReset();
      enable = 1'b1;
      modelFrame();
      repeat (101) @(negedge clk);
      level = 16'hFFFF;
      level_valid = 1'b1;
      @(negedge clk);
      level_valid = 1'b0;
      modelSample(16'hFFFF);
      vectors++;
      if (frame_start !== 1'b1 || sb.size() == 0) begin
         miscompares++;
         $display("FAIL bnd_start start=%b required 1", frame_start);
      end else begin
         e = sb.pop_front();
         if (on_count !== 16'(e.on) || peak_count !== 16'(e.peak) || on_count !== 16'd0) begin
            miscompares++;
            $display("FAIL bnd_excluded on=%0d peak=%0d required %0d/%0d", on_count, peak_count, e.on, e.peak);
         end
      end
      pulseDone(10);
      modelFrame();
      waitStart(200, ok, cyc);
      vectors++;
      if (!ok || sb.size() == 0) begin
         miscompares++;
         $display("FAIL bnd_next_timeout ok=%b", ok);
      end else begin
         e = sb.pop_front();
         if (on_count !== 16'(e.on) || peak_count !== 16'(e.peak) || on_count !== 16'd60) begin
            miscompares++;
            $display("FAIL bnd_included on=%0d peak=%0d required %0d/%0d", on_count, peak_count, e.on, e.peak);
         end
      end
   endtask

   // Runs straight after test_boundary, sitting on the START cycle of a 60/60 frame.
   task automatic test_async_reset();
      logic ok; int cyc; int active; exp_t e;
      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      vectors++;
      if (drv_enable !== 1'b0 || frame_start !== 1'b0 || on_count !== 16'd0 || peak_count !== 16'd0 ||
          max_count !== 16'd60 || overrun !== 1'b0) begin
         miscompares++;
         $display("FAIL arst_outputs drv=%b start=%b on=%0d peak=%0d max=%0d ovr=%b required 0 0 0 0 60 0",
                  drv_enable, frame_start, on_count, peak_count, max_count, overrun);
      end
      enable = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      modelClear();
      pulseDone(2);
      active = 0;
      repeat (150) begin
         @(negedge clk);
         if (frame_start || drv_enable) active++;
      end
      vectors++;
      if (active != 0) begin
         miscompares++;
         $display("FAIL arst_done_ignored active_cycles=%0d required 0", active);
      end
      enable = 1'b1;
      modelFrame();
      @(negedge clk);
      frame_done = 1'b1;
      @(negedge clk);
      frame_done = 1'b0;
      waitStart(200, ok, cyc);
      vectors++;
      if (!ok || cyc != 100 || sb.size() == 0) begin
         miscompares++;
         $display("FAIL arst_armed_done ok=%b cycles=%0d required 100", ok, cyc);
      end else begin
         e = sb.pop_front();
         if (on_count !== 16'(e.on) || peak_count !== 16'(e.peak)) begin
            miscompares++;
            $display("FAIL arst_vals on=%0d peak=%0d required %0d/%0d", on_count, peak_count, e.on, e.peak);
         end
      end
      pulseDone(10);
   endtask

   initial begin
      modelClear();
      test_reset();
      test_attack();
      test_decay();
      test_overrun();
      test_disable();
      test_boundary();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
